// File: rtl/div32.sv
// 32-bit restoring divider: one shift-subtract step per cycle, 33-cycle latency.
// Define DIV32_SIGNED_EN to enable two's-complement division via the Signed input.
module div32 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Signed,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        DivZero,
    output logic        Over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic        div_zero;
    logic        sneg_a;
    logic        sneg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    logic [32:0] partial;
    logic        qbit;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    assign accept   = (state == IDLE) && Start;
    assign div_zero = (Divisor == '0);

`ifdef DIV32_SIGNED_EN
    logic ovf;
    logic ovf_in;

    always_comb begin
        sneg_a = Signed & Dividend[31];
        sneg_b = Signed & Divisor[31];
        mag_a  = sneg_a ? (32'd0 - Dividend) : Dividend;
        mag_b  = sneg_b ? (32'd0 - Divisor)  : Divisor;
        ovf_in = Signed && (Dividend == 32'h8000_0000) && (Divisor == '1);
    end
`else
    logic unused_signed;

    assign unused_signed = Signed;
    assign sneg_a        = 1'b0;
    assign sneg_b        = 1'b0;
    assign mag_a         = Dividend;
    assign mag_b         = Divisor;
    assign Over          = 1'b0;
`endif

    // Dividend bits are shifted out of quo's MSB while quotient bits enter at its LSB.
    always_comb begin
        partial = {rem, quo[31]} - {1'b0, dvsr};
        qbit    = ~partial[32];
        rem_nx  = qbit ? partial[31:0] : {rem[30:0], quo[31]};
        quo_nx  = {quo[30:0], qbit};
        q_fin   = neg_q ? (32'd0 - quo_nx) : quo_nx;
        r_fin   = neg_r ? (32'd0 - rem_nx) : rem_nx;
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nx = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == 5'd31) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                Busy     = 1'b1;
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
`ifdef DIV32_SIGNED_EN
            ovf       <= 1'b0;
            Over      <= 1'b0;
`endif
        end else if (accept) begin
            if (div_zero) begin
                Quotient  <= '1;
                Remainder <= Dividend;
                DivZero   <= 1'b1;
`ifdef DIV32_SIGNED_EN
                Over      <= 1'b0;
`endif
            end else begin
                cnt   <= '0;
                rem   <= '0;
                quo   <= mag_a;
                dvsr  <= mag_b;
                neg_q <= sneg_a ^ sneg_b;
                neg_r <= sneg_a;
`ifdef DIV32_SIGNED_EN
                ovf   <= ovf_in;
`endif
            end
        end else if (state == RUN) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                Quotient  <= q_fin;
                Remainder <= r_fin;
                DivZero   <= 1'b0;
`ifdef DIV32_SIGNED_EN
                Over      <= ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_div32.sv
// Randomized bench for div32 with an arithmetic reference model and literal spot checks.
// Honours DIV32_SIGNED_EN the same way the design does.
module tb_div32;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Signed;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        Busy;
    logic        Done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        DivZero;
    logic        Over;

    div32 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Signed    (Signed),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero),
        .Over      (Over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference result straight from the arithmetic definition of division.
    function automatic void calc(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz, output logic ov);
        int sa;
        int sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
`ifdef DIV32_SIGNED_EN
            if (s) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q  = 32'h8000_0000;
                    r  = 32'd0;
                    ov = 1'b1;
                end else begin
                    sa = a;
                    sb = b;
                    q  = sa / sb;
                    r  = sa % sb;
                end
            end
`else
            sa = 0;
            sb = int'(s);
`endif
        end
    endfunction

    // Model: m_left counts cycles still owed to the current operation (1 = Done cycle).
    int          m_left = 0;
    logic        mvalid = 1'b0;
    logic [31:0] exp_q, exp_r, pq, pr;
    logic        exp_dz, exp_ov, pdz, pov;

    always @(posedge Clk) begin : model
        logic [31:0] q, r;
        logic        dz, ov;
        cyc <= cyc + 1;
        if (!Reset) begin
            mvalid <= 1'b1;
            m_left <= 0;
            exp_q  <= '0;
            exp_r  <= '0;
            exp_dz <= 1'b0;
            exp_ov <= 1'b0;
        end else if (m_left > 1) begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                exp_q  <= pq;
                exp_r  <= pr;
                exp_dz <= pdz;
                exp_ov <= pov;
            end
        end else if (m_left == 1) begin
            m_left <= 0;
        end else if (Start) begin
            calc(Signed, Dividend, Divisor, q, r, dz, ov);
            pq  <= q;
            pr  <= r;
            pdz <= dz;
            pov <= ov;
            if (Divisor == 32'd0) begin
                m_left <= 1;
                exp_q  <= q;
                exp_r  <= r;
                exp_dz <= dz;
                exp_ov <= ov;
            end else begin
                m_left <= 33;
            end
        end
    end

    always @(negedge Clk) begin
        if (mvalid) begin
            check("busy",      {31'd0, Busy},    {31'd0, m_left != 0});
            check("done",      {31'd0, Done},    {31'd0, m_left == 1});
            check("quotient",  Quotient,         exp_q);
            check("remainder", Remainder,        exp_r);
            check("divzero",   {31'd0, DivZero}, {31'd0, exp_dz});
            check("over",      {31'd0, Over},    {31'd0, exp_ov});
        end
    end

    // Issue one operation in the next cycle, scribble on inputs while busy, wait for Done.
    task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
        int want;
        want = (b == 32'd0) ? 1 : 33;
        @(negedge Clk);
        Start    = 1'b1;
        Signed   = s;
        Dividend = a;
        Divisor  = b;
        lat      = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (Done) begin
                lat   = k;
                Start = 1'b0;
                break;
            end
            Start    = ($urandom_range(0, 3) == 0);
            Signed   = $urandom_range(0, 1) == 1;
            Dividend = $urandom;
            Divisor  = $urandom;
        end
        Start = 1'b0;
        check("latency", 32'(lat), 32'(want));
    endtask

    int lat;

    initial begin : stim
        logic        s;
        logic [31:0] a, b;
        Reset    = 1'b0;
        Start    = 1'b0;
        Signed   = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_q",    Quotient,      32'd0);
        Reset = 1'b1;

        op(1'b0, 32'd100, 32'd7, lat);
        check("d100_7_q",  Quotient,  32'd14);
        check("d100_7_r",  Remainder, 32'd2);
        check("d100_7_dz", {31'd0, DivZero}, 32'd0);

        op(1'b0, 32'hFFFF_FFFF, 32'd1, lat);
        check("dmax_1_q", Quotient,  32'hFFFF_FFFF);
        check("dmax_1_r", Remainder, 32'd0);
        op(1'b0, 32'h1234_5678, 32'h10, lat);
        check("b2b_q", Quotient,  32'h0123_4567);
        check("b2b_r", Remainder, 32'd8);

        op(1'b0, 32'd5, 32'd0, lat);
        check("dz_q",  Quotient,  32'hFFFF_FFFF);
        check("dz_r",  Remainder, 32'd5);
        check("dz_dz", {31'd0, DivZero}, 32'd1);

        op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
`ifdef DIV32_SIGNED_EN
        check("sgn_q", Quotient,  32'hFFFF_FFFD);
        check("sgn_r", Remainder, 32'hFFFF_FFFF);
`else
        check("sgn_q", Quotient,  32'h7FFF_FFFC);
        check("sgn_r", Remainder, 32'd1);
`endif

        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
`ifdef DIV32_SIGNED_EN
        check("ovf_q", Quotient,  32'h8000_0000);
        check("ovf_r", Remainder, 32'd0);
        check("ovf_o", {31'd0, Over}, 32'd1);
`else
        check("ovf_q", Quotient,  32'd0);
        check("ovf_r", Remainder, 32'h8000_0000);
        check("ovf_o", {31'd0, Over}, 32'd0);
`endif

        // Abort: ignored Start while busy, then reset (with Start held) mid-operation.
        @(negedge Clk);
        Start    = 1'b1;
        Signed   = 1'b0;
        Dividend = 32'd100;
        Divisor  = 32'd7;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            check("abort_nodone", {31'd0, Done}, 32'd0);
            Start = 1'b0;
            if (c == 10) begin
                Start    = 1'b1;
                Dividend = 32'd9;
                Divisor  = 32'd3;
            end
            if (c == 20) begin
                Reset    = 1'b0;
                Start    = 1'b1;
                Dividend = 32'd1;
                Divisor  = 32'd1;
            end
            if (c == 21) begin
                Reset = 1'b1;
                check("abort_busy", {31'd0, Busy},    32'd0);
                check("abort_q",    Quotient,         32'd0);
                check("abort_r",    Remainder,        32'd0);
                check("abort_dz",   {31'd0, DivZero}, 32'd0);
                check("abort_ov",   {31'd0, Over},    32'd0);
            end
        end
        op(1'b0, 32'd9, 32'd3, lat);
        check("fresh_q", Quotient,  32'd3);
        check("fresh_r", Remainder, 32'd0);

        for (int i = 0; i < 80; i++) begin
            s = $urandom_range(0, 1) == 1;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'd1;
                3: b = $urandom_range(1, 15);
                4: a = $urandom_range(0, 100);
                5: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            op(s, a, b, lat);
        end

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div32.md
DIV32 -- requirements
Module: div32

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 32 bits.
REQ-002 Clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 Reset  input  1  synchronous, active-low reset; sampled on rising Clk.
REQ-004 Start  input  1  request a division; accepted only in IDLE.
REQ-005 Signed  input  1  1 = two's-complement operands; sampled with Start.
REQ-006 Dividend  input  32  numerator; sampled with Start.
REQ-007 Divisor  input  32  denominator; sampled with Start.
REQ-008 Busy  output  1  high from the cycle after acceptance through the Done cycle inclusive.
REQ-009 Done  output  1  one-cycle pulse; Quotient/Remainder/DivZero/Over valid from this cycle.
REQ-010 Quotient  output  32  registered quotient.
REQ-011 Remainder  output  32  registered remainder.
REQ-012 DivZero  output  1  Divisor was zero for the last completed operation.
REQ-013 Over  output  1  signed overflow (0x80000000 / -1) for the last completed operation.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; no other reachable states.
REQ-015 IDLE->RUN on Start=1 with nonzero Divisor; IDLE->DONE on Start=1 with Divisor=0; otherwise stay IDLE.
REQ-016 RUN SHALL perform exactly one restoring shift-subtract step per cycle for 32 cycles (5-bit step counter 0..31), then go to DONE.
REQ-017 DONE SHALL last one cycle, assert Done, then return to IDLE.
REQ-018 Latency: Done SHALL assert 33 cycles after the Start-sampling edge for nonzero Divisor, 1 cycle for zero Divisor.
REQ-019 Start while Busy (RUN or DONE) SHALL be ignored; operand inputs SHALL be don't-care outside the accept cycle.
REQ-020 Each step: partial remainder (33-bit) = {rem,next dividend bit} minus divisor; sign bit clear -> keep difference, quotient bit 1; else restore, quotient bit 0.
REQ-021 Unsigned result: Dividend = Quotient*Divisor + Remainder, Remainder < Divisor.
REQ-022 Divide by zero: Quotient=0xFFFFFFFF, Remainder=Dividend, DivZero=1, Over=0.
REQ-023 Quotient, Remainder, DivZero, Over SHALL hold their values from Done until the next Done; they SHALL NOT change during RUN.
REQ-024 Back-to-back: Start in the cycle after Done (IDLE) SHALL be accepted with no extra dead cycle.

Reset
REQ-025 Reset=0 at a rising edge SHALL force IDLE, counter 0, Busy=0, Done=0, Quotient=0, Remainder=0, DivZero=0, Over=0.
REQ-026 Reset mid-operation SHALL abort it; no Done SHALL be produced for the aborted operation.
REQ-027 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-028 Macro DIV32_SIGNED_EN defined: Signed=1 operations SHALL use magnitudes, negate quotient when operand signs differ, give Remainder the sign of Dividend (truncation toward zero); 0x80000000 / 0xFFFFFFFF SHALL yield Quotient=0x80000000, Remainder=0, Over=1 (with full 33-cycle latency); signed divide by zero per REQ-022.
REQ-029 Macro undefined: Signed port SHALL remain present but be ignored; all operations unsigned; Over SHALL be constant 0.

Verification
REQ-030 Unsigned 100 / 7 -> Done at cycle 33, Quotient=14, Remainder=2, DivZero=0, Over=0.
REQ-031 0xFFFFFFFF / 1 -> Quotient=0xFFFFFFFF, Remainder=0; then immediate Start 0x12345678 / 0x10 -> Quotient=0x01234567, Remainder=8, no dead cycle.
REQ-032 5 / 0 -> Done at cycle 1, Quotient=0xFFFFFFFF, Remainder=5, DivZero=1.
REQ-033 Signed=1, 0xFFFFFFF9 (-7) / 2 -> with DIV32_SIGNED_EN Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF; without Quotient=0x7FFFFFFC, Remainder=1.
REQ-034 With DIV32_SIGNED_EN, Signed=1, 0x80000000 / 0xFFFFFFFF -> Quotient=0x80000000, Remainder=0, Over=1.
REQ-035 Start 100 / 7, Start 9 / 3 at cycle 10 (ignored), Reset=0 at cycle 20 -> no Done, all outputs 0; fresh 9 / 3 afterwards -> Quotient=3, Remainder=0 at cycle 33.
